// File: rtl/passage_sequencer.sv
// passage_sequencer: emits entry/exit beam patterns for a passage; optional occupancy counter under PASSAGE_OCC_COUNT_EN
module passage_sequencer #(
  parameter int PHASE_CYC = 4
) (
  input  logic       CLK,
  input  logic       KEY,
  input  logic [1:0] SW,
  input  logic       START,
  output logic [1:0] SENS,
  output logic       BUSY,
  output logic [6:0] HEX0,
  output logic       LEDG,
  output logic       LEDR,
  output logic [3:0] OCC
);
  typedef enum logic [2:0] {IDLE, P1, P2, P3, DONE, ERR} state_t;
  localparam logic [7:0] LAST = 8'(PHASE_CYC - 1);
  localparam logic [6:0] HEX_BLANK = 7'b1111111;
  localparam logic [6:0] HEX_E = 7'b0110000;
  localparam logic [6:0] HEX_S = 7'b0100100;
  localparam logic [6:0] HEX_DASH = 7'b1111110;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic dir_q, dir_d;
  logic ledr_q, ledr_d;
  logic last;
  logic [6:0] hex_dir;
  // next-state, phase timing and decoded outputs
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    dir_d = dir_q;
    ledr_d = ledr_q;
    SENS = 2'b00;
    BUSY = 1'b0;
    HEX0 = HEX_BLANK;
    LEDG = 1'b0;
    last = cnt_q == LAST;
    hex_dir = dir_q ? HEX_E : HEX_S;
    case (state_q)
      IDLE: if (START) begin
        state_d = (SW == 2'b10 || SW == 2'b01) ? P1 : ERR;
        dir_d = (SW == 2'b10 || SW == 2'b01) ? SW[1] : dir_q;
        ledr_d = !(SW == 2'b10 || SW == 2'b01);
      end
      P1, P2, P3: begin
        BUSY = 1'b1;
        HEX0 = hex_dir;
        cnt_d = last ? 8'd0 : cnt_q + 8'd1;
        state_d = !last ? state_q : state_q == P1 ? P2 : state_q == P2 ? P3 : DONE;
        SENS = state_q == P2 ? 2'b11 : (state_q == P1) == dir_q ? 2'b10 : 2'b01;
      end
      DONE: begin
        BUSY = 1'b1;
        HEX0 = hex_dir;
        LEDG = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        HEX0 = HEX_DASH;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, phase counter, latched direction and sticky error flag
  always_ff @(posedge CLK) begin
    if (!KEY) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dir_q <= 1'b0;
      ledr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      ledr_q <= ledr_d;
    end
  end
  assign LEDR = ledr_q;
`ifdef PASSAGE_OCC_COUNT_EN
  logic [3:0] occ_q;
  // saturating occupancy update on each completed sequence
  always_ff @(posedge CLK) begin
    if (!KEY) occ_q <= '0;
    else if (state_q == DONE) occ_q <= dir_q ? (occ_q == 4'd15 ? occ_q : occ_q + 4'd1) : (occ_q == 4'd0 ? occ_q : occ_q - 4'd1);
  end
  assign OCC = occ_q;
`else
  assign OCC = 4'd0;
`endif
endmodule

// File: doc/passage_sequencer.md
PASSAGE_SEQUENCER -- requirements
Module: passage_sequencer

Interface
REQ-001 SHALL have parameter PHASE_CYC, default 4, clock cycles per sensor phase; legal range 1..255.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port KEY  input  1  reset, synchronous, active-low (KEY[0]).
REQ-004 SHALL have port SW  input  2  command select; SW[1] = entrada (entry), SW[0] = saida (exit).
REQ-005 SHALL have port START  input  1  level-high start request, sampled only in IDLE.
REQ-006 SHALL have port SENS  output  2  emitted sensor pattern; SENS[1] = outer beam, SENS[0] = inner beam, 1 = blocked.
REQ-007 SHALL have port BUSY  output  1  high while a sequence is being emitted.
REQ-008 SHALL have port HEX0  output  7  active-low segments, bit order abcdefg.
REQ-009 SHALL have port LEDG  output  1  one-cycle done pulse.
REQ-010 SHALL have port LEDR  output  1  sticky command-error flag.
REQ-011 SHALL have port OCC  output  4  occupancy count, see Configuration.

Function
REQ-012 SHALL implement states IDLE, P1, P2, P3, DONE, ERR.
REQ-013 In IDLE with START=1: SW=2'b10 -> P1, direction latched as entry; SW=2'b01 -> P1, direction latched as exit; SW=2'b00 or 2'b11 -> ERR.
REQ-014 SHALL latch SW only on the IDLE->P1 transition; SW changes during P1..DONE SHALL have no effect.
REQ-015 SHALL ignore START in every state except IDLE.
REQ-016 Entry: SENS SHALL be 10 in P1, 11 in P2, 01 in P3; exit: 01 in P1, 11 in P2, 10 in P3; SENS SHALL be 00 in IDLE, DONE, ERR.
REQ-017 Each of P1, P2, P3 SHALL last exactly PHASE_CYC cycles, timed by an 8-bit phase counter cleared on every phase entry.
REQ-018 P3 expiry -> DONE; DONE SHALL last one cycle with LEDG=1, then -> IDLE.
REQ-019 Total emission SHALL be 3*PHASE_CYC cycles of nonzero SENS, first nonzero SENS in the cycle after START is sampled.
REQ-020 BUSY SHALL be 1 in P1, P2, P3, DONE and 0 in IDLE, ERR.
REQ-021 ERR SHALL set LEDR=1 and return to IDLE next cycle; LEDR SHALL stay 1 until the next valid start (IDLE->P1), which clears it.
REQ-022 HEX0: IDLE blank 1111111; entry P1..DONE "E" 0110000; exit P1..DONE "S" 0100100; ERR dash 1111110.
REQ-023 START held high through DONE SHALL start a new sequence on the first IDLE cycle (back-to-back allowed, one IDLE cycle minimum between sequences).
REQ-024 Any undefined state encoding SHALL go to IDLE next cycle.

Reset
REQ-025 KEY=0 at a rising CLK edge SHALL force IDLE, SENS=00, BUSY=0, LEDG=0, LEDR=0, HEX0=1111111, OCC=0, phase counter=0.
REQ-026 Reset mid-sequence SHALL abort immediately with no LEDG pulse and no OCC change.
REQ-027 Reset SHALL have priority over START in the same cycle.

Configuration
REQ-028 Macro PASSAGE_OCC_COUNT_EN defined: OCC SHALL increment on each entry DONE, decrement on each exit DONE, saturating at 15 and 0.
REQ-029 Macro PASSAGE_OCC_COUNT_EN undefined: OCC SHALL be constant 4'd0 and no counter register SHALL be built.

Verification
REQ-030 Reset, SW=10, START=1 one cycle, PHASE_CYC=4 -> SENS 10x4, 11x4, 01x4, then LEDG=1 one cycle, HEX0=0110000 throughout, BUSY low after DONE.
REQ-031 SW=01, START pulse, SW toggled to 10 during P2 -> SENS 01,11,10 unchanged, HEX0=0100100.
REQ-032 SW=11 with START -> LEDR=1, HEX0=1111110 one cycle, BUSY=0; next valid start clears LEDR.
REQ-033 KEY=0 during P2 of an entry -> next cycle SENS=00, BUSY=0, no LEDG, OCC unchanged.
REQ-034 With PASSAGE_OCC_COUNT_EN: 16 entries -> OCC=15 (saturated); 1 exit -> 14; from 0, 1 exit -> OCC stays 0.
REQ-035 START held high with SW=10, PHASE_CYC=1 -> repeated sequences, each 3 SENS cycles + DONE + one IDLE cycle.
